// File: rtl/sobel_pkg.sv
// Shared types, widths and kernel constants for the streaming 3x3 Sobel edge detector.
package sobel_pkg;

    localparam int PIX_W   = 8;
    localparam int GRAD_W  = 11;
    localparam int MAG_W   = 12;
    localparam int MAG_MAX = 255;

    typedef logic        [PIX_W-1:0]  pix_t;
    typedef logic signed [GRAD_W-1:0] grad_t;
    typedef logic        [MAG_W-1:0]  mag_t;

    typedef enum logic {
        ST_FILL,
        ST_RUN
    } ctrl_state_t;

    // Indexed [row][col]; row 0 is the oldest line, col 2 the newest pixel.
    localparam logic signed [2:0] SOBEL_KX [3][3] = '{
        '{-3'sd1, 3'sd0, 3'sd1},
        '{-3'sd2, 3'sd0, 3'sd2},
        '{-3'sd1, 3'sd0, 3'sd1}
    };
    localparam logic signed [2:0] SOBEL_KY [3][3] = '{
        '{-3'sd1, -3'sd2, -3'sd1},
        '{ 3'sd0,  3'sd0,  3'sd0},
        '{ 3'sd1,  3'sd2,  3'sd1}
    };

    function automatic mag_t abs_grad(input grad_t g);
        logic [GRAD_W-1:0] a;
        a = (g < 0) ? -g : g;
        return mag_t'(a);
    endfunction

    function automatic pix_t saturate(input mag_t m);
        return (m > mag_t'(MAG_MAX)) ? pix_t'(MAG_MAX) : m[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of pixels: synchronous write, combinational read at the same address.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH  = 640,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [PIX_W-1:0]  wdata_i,
    output logic [PIX_W-1:0]  rdata_o
);

    pix_t mem [DEPTH];

    // NOTE: the RAM has no reset; stale lines are masked by the row counter, and a reset
    // port would stop this from mapping onto block/distributed RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[addr_i];

endmodule

// File: rtl/gray_sobel_3x3.sv
// Streaming 3x3 Sobel |Gx|+|Gy| over a raster grayscale stream, three pipeline stages.
// Optional binarised output when SOBEL_THRESHOLD_EN is defined (out_edge = 255 when mag >= THRESH).
module gray_sobel_3x3
    import sobel_pkg::*;
#(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int THRESH = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_gray,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_edge,
    output logic             out_eof
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

`ifdef SOBEL_THRESHOLD_EN
    localparam bit THRESH_EN = 1'b1;
`else
    localparam bit THRESH_EN = 1'b0;
`endif

    logic [COL_W-1:0] col_q, col_d, cur_col;
    logic [ROW_W-1:0] row_q, row_d, cur_row;
    ctrl_state_t      state_q;

    pix_t  p_q [3][3];
    pix_t  lb0_rd, lb1_rd;
    logic  complete, frame_last;
    logic  v1_q, eof1_q, v2_q, eof2_q;
    grad_t gx_d, gy_d, gx_q, gy_q;
    mag_t  mag;
    pix_t  edge_d;
    logic  out_valid_q, out_eof_q;
    pix_t  out_edge_q;

    // A sof pixel is treated as (0,0) whatever the counters held.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cur_col = in_sof ? '0 : col_q;
        cur_row = in_sof ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (in_valid) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
        end
    end

    assign complete   = in_valid && !in_sof && (state_q == ST_RUN) && (col_q >= COL_W'(2));
    assign frame_last = complete && (row_q == ROW_LAST) && (col_q == COL_LAST);

    sobel_line_buffer #(.DEPTH(IMG_W), .ADDR_W(COL_W)) u_line0 (
        .clk     (clk),
        .we_i    (in_valid),
        .addr_i  (cur_col),
        .wdata_i (in_gray),
        .rdata_o (lb0_rd)
    );

    sobel_line_buffer #(.DEPTH(IMG_W), .ADDR_W(COL_W)) u_line1 (
        .clk     (clk),
        .we_i    (in_valid),
        .addr_i  (cur_col),
        .wdata_i (lb0_rd),
        .rdata_o (lb1_rd)
    );

    // Stage 1: counters, FILL/RUN control and the 3x3 window.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            state_q <= ST_FILL;
            v1_q    <= 1'b0;
            eof1_q  <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    p_q[r][c] <= '0;
                end
            end
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            v1_q   <= complete;
            eof1_q <= frame_last;
            case (state_q)
                ST_FILL: if (row_d >= ROW_W'(2)) state_q <= ST_RUN;
                ST_RUN:  if (row_d <  ROW_W'(2)) state_q <= ST_FILL;
                default: state_q <= ST_FILL;
            endcase
            if (in_valid) begin
                for (int r = 0; r < 3; r++) begin
                    p_q[r][0] <= p_q[r][1];
                    p_q[r][1] <= p_q[r][2];
                end
                p_q[0][2] <= lb1_rd;
                p_q[1][2] <= lb0_rd;
                p_q[2][2] <= in_gray;
            end
        end
    end

    always_comb begin
        gx_d = '0;
        gy_d = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                gx_d = gx_d + grad_t'(SOBEL_KX[r][c]) * grad_t'({3'b000, p_q[r][c]});
                gy_d = gy_d + grad_t'(SOBEL_KY[r][c]) * grad_t'({3'b000, p_q[r][c]});
            end
        end
    end

    // Stage 2: gradients.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gx_q   <= '0;
            gy_q   <= '0;
            v2_q   <= 1'b0;
            eof2_q <= 1'b0;
        end else begin
            gx_q   <= gx_d;
            gy_q   <= gy_d;
            v2_q   <= v1_q;
            eof2_q <= eof1_q;
        end
    end

    // Threshold compares the full-width magnitude, before any saturation.
    always_comb begin
        mag    = abs_grad(gx_q) + abs_grad(gy_q);
        edge_d = saturate(mag);
        if (THRESH_EN) begin
            edge_d = (mag >= MAG_W'(THRESH)) ? pix_t'(MAG_MAX) : '0;
        end
    end

    // Stage 3: registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_edge_q  <= '0;
            out_eof_q   <= 1'b0;
        end else begin
            out_valid_q <= v2_q;
            out_edge_q  <= edge_d;
            out_eof_q   <= eof2_q;
        end
    end

    assign out_valid = out_valid_q;
    assign out_edge  = out_edge_q;
    assign out_eof   = out_eof_q;

endmodule

// File: tb/tb_gray_sobel_3x3.sv
// Directed self-checking bench for gray_sobel_3x3 on a 5x4 image (6 interior outputs per frame).
module tb_gray_sobel_3x3;

    localparam int W = 5;
    localparam int H = 4;
`ifdef SOBEL_THRESHOLD_EN
    localparam bit THR = 1'b1;
`else
    localparam bit THR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_sof;
    logic [7:0] in_gray;
    logic       out_valid, out_eof;
    logic [7:0] out_edge;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] got_val [$];
    logic       got_eof [$];
    int         got_cyc [$];
    int         acc_q   [$];

    gray_sobel_3x3 #(.IMG_W(W), .IMG_H(H), .THRESH(100)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_gray   (in_gray),
        .out_valid (out_valid),
        .out_edge  (out_edge),
        .out_eof   (out_eof)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Outputs are captured on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (out_valid) begin
            got_val.push_back(out_edge);
            got_eof.push_back(out_eof);
            got_cyc.push_back(cyc);
        end
    end

    // kind: 0 flat 100, 1 vertical step, 2 ramp 10*col, 3 ramp 30*col, 4 random
    function automatic logic [7:0] pix(input int kind, input int c);
        case (kind)
            0:       return 8'd100;
            1:       return (c < 2) ? 8'd0 : 8'd255;
            2:       return 8'(10 * c);
            3:       return 8'(30 * c);
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // Hand-derived output value for output i of a frame of the given kind.
    function automatic int exp_edge(input int kind, input int i);
        case (kind)
            0:       return 0;
            1:       return (i % 3 == 2) ? 0 : 255;
            2:       return THR ? 0 : 80;
            default: return THR ? 255 : 240;
        endcase
    endfunction

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // acc is the edge number (value cyc takes) at which the pixel is accepted.
    task automatic drive(input logic sof, input logic [7:0] g, output int acc);
        in_valid = 1'b1;
        in_sof   = sof;
        in_gray  = g;
        acc      = cyc + 1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    // gap_mode: 0 continuous, 1 one idle cycle after each pixel, 2 random 0..3 idle cycles
    task automatic send_frame(input int kind, input int gap_mode, input logic with_sof);
        int acc;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                drive(with_sof && r == 0 && c == 0, pix(kind, c), acc);
                if (r >= 2 && c >= 2) acc_q.push_back(acc);
                if (gap_mode == 1) idle(1);
                else if (gap_mode == 2) idle($urandom_range(0, 3));
            end
        end
    endtask

    task automatic clear();
        got_val.delete();
        got_eof.delete();
        got_cyc.delete();
        acc_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        checks++;
        if (out_valid !== 1'b0 || out_edge !== 8'd0 || out_eof !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b e=%0d eof=%b expected 0 0 0", out_valid, out_edge, out_eof);
        end
        rst = 1'b0;
        idle(2);
        checks++;
        if (got_val.size() != 0) begin
            errors++;
            $display("FAIL reset_idle_count: got %0d outputs expected 0", got_val.size());
        end
    endtask

    task automatic test_patterns();
        for (int k = 0; k < 4; k++) begin
            clear();
            send_frame(k, 0, 1'b1);
            idle(6);
            checks++;
            if (got_val.size() != 6) begin
                errors++;
                $display("FAIL pattern%0d_count: got %0d expected 6", k, got_val.size());
            end
            for (int i = 0; i < got_val.size() && i < 6; i++) begin
                checks++;
                if (got_val[i] !== 8'(exp_edge(k, i)) || got_eof[i] !== (i == 5)) begin
                    errors++;
                    $display("FAIL pattern%0d_out[%0d]: got %0d eof=%b expected %0d eof=%b",
                             k, i, got_val[i], got_eof[i], exp_edge(k, i), i == 5);
                end
                checks++;
                if (got_cyc[i] != acc_q[i] + 2) begin
                    errors++;
                    $display("FAIL pattern%0d_latency[%0d]: got edge %0d expected %0d", k, i, got_cyc[i], acc_q[i] + 2);
                end
            end
        end
    endtask

    task automatic test_gaps();
        for (int g = 1; g <= 2; g++) begin
            clear();
            send_frame(2, g, 1'b1);
            idle(6);
            checks++;
            if (got_val.size() != 6) begin
                errors++;
                $display("FAIL gaps%0d_count: got %0d expected 6", g, got_val.size());
            end
            for (int i = 0; i < got_val.size() && i < 6; i++) begin
                checks++;
                if (got_val[i] !== 8'(exp_edge(2, i)) || got_eof[i] !== (i == 5) || got_cyc[i] != acc_q[i] + 2) begin
                    errors++;
                    $display("FAIL gaps%0d_out[%0d]: got %0d eof=%b edge %0d expected %0d eof=%b edge %0d",
                             g, i, got_val[i], got_eof[i], got_cyc[i], exp_edge(2, i), i == 5, acc_q[i] + 2);
                end
            end
        end
    endtask

    // Two frames with no gap and no second sof: the row wrap alone must restart the frame.
    task automatic test_back_to_back();
        clear();
        send_frame(1, 0, 1'b1);
        send_frame(1, 0, 1'b0);
        idle(6);
        checks++;
        if (got_val.size() != 12) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 12", got_val.size());
        end
        for (int i = 0; i < got_val.size() && i < 12; i++) begin
            checks++;
            if (got_val[i] !== 8'(exp_edge(1, i % 6)) || got_eof[i] !== (i % 6 == 5)) begin
                errors++;
                $display("FAIL b2b_out[%0d]: got %0d eof=%b expected %0d eof=%b",
                         i, got_val[i], got_eof[i], exp_edge(1, i % 6), i % 6 == 5);
            end
        end
    endtask

    task automatic test_sof_resync();
        int acc;
        clear();
        for (int i = 0; i < 7; i++) drive(1'b0, pix(4, 0), acc);
        send_frame(2, 0, 1'b1);
        idle(6);
        checks++;
        if (got_val.size() != 6) begin
            errors++;
            $display("FAIL sof_resync_count: got %0d expected 6", got_val.size());
        end
        for (int i = 0; i < got_val.size() && i < 6; i++) begin
            checks++;
            if (got_val[i] !== 8'(exp_edge(2, i)) || got_cyc[i] != acc_q[i] + 2) begin
                errors++;
                $display("FAIL sof_resync_out[%0d]: got %0d at edge %0d expected %0d at edge %0d",
                         i, got_val[i], got_cyc[i], exp_edge(2, i), acc_q[i] + 2);
            end
        end
    endtask

    // The sof lands where pixel (2,2) would have completed a window: no output for it.
    task automatic test_sof_on_complete();
        int acc;
        clear();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < W && !(r == 2 && c == 2); c++) drive(1'b0, pix(2, c), acc);
        end
        send_frame(2, 0, 1'b1);
        idle(6);
        checks++;
        if (got_val.size() != 6) begin
            errors++;
            $display("FAIL sof_complete_count: got %0d expected 6", got_val.size());
        end
        checks++;
        if (got_val.size() > 0 && got_cyc[0] != acc_q[0] + 2) begin
            errors++;
            $display("FAIL sof_complete_first: got edge %0d expected %0d", got_cyc[0], acc_q[0] + 2);
        end
    endtask

    task automatic test_reset_mid_frame();
        int acc;
        clear();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < W; c++) drive(r == 0 && c == 0, pix(2, c), acc);
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_inflight: got out_valid=%b expected 1", out_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_edge !== 8'd0 || out_eof !== 1'b0) begin
            errors++;
            $display("FAIL midrst_immediate: got v=%b e=%0d eof=%b expected 0 0 0", out_valid, out_edge, out_eof);
        end
        idle(3);
        rst = 1'b0;
        idle(1);
        checks++;
        if (got_val.size() != 0) begin
            errors++;
            $display("FAIL midrst_discard: got %0d outputs expected 0", got_val.size());
        end
        clear();
        send_frame(2, 0, 1'b0);
        idle(6);
        checks++;
        if (got_val.size() != 6) begin
            errors++;
            $display("FAIL midrst_next_count: got %0d expected 6", got_val.size());
        end
        for (int i = 0; i < got_val.size() && i < 6; i++) begin
            checks++;
            if (got_val[i] !== 8'(exp_edge(2, i)) || got_eof[i] !== (i == 5)) begin
                errors++;
                $display("FAIL midrst_next_out[%0d]: got %0d eof=%b expected %0d eof=%b",
                         i, got_val[i], got_eof[i], exp_edge(2, i), i == 5);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_gray  = 8'd0;
        test_reset();
        test_patterns();
        test_gaps();
        test_back_to_back();
        test_sof_resync();
        test_sof_on_complete();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
